// File: rtl/swicth_conf_control_gen.sv
// rtl/swicth_conf_control_gen.sv - per-thread switch configuration memory with PC sequencing and output pipe
//
// Purpose:
//   Holds one configuration word per (thread, pc) pair. The block steps
//   round-robin through the threads. On each step it reads the current word of
//   the selected thread and advances that thread's program counter. The word
//   read is then delayed through a fixed-depth output pipe. After reset an INIT
//   sweep clears the memory. Configuration commands are accepted only once the
//   sweep has finished.
//
// Ports:
//   clk                 rising-edge clock
//   rst                 asynchronous active-high reset
//   en_pc_net           step enable (thread counter, PC, memory read, output pipe)
//   conf_valid          command valid
//   conf_ready          command accepted (high in RUN only)
//   conf_cmd            0 write word, 1 set pc_max, 2 set pc_loop, 3 set active
//   conf_thread         target thread
//   conf_addr           target word address for cmd 0
//   conf_data           command payload
//   swicth_conf_out     pipelined configuration word (zero for inactive threads)
//   swicth_conf_thread  thread index aligned with swicth_conf_out
//   swicth_id           constant SWICTH_NUMBER

module swicth_conf_control_gen #(
  parameter int SWICTH_NUMBER = 0,
  parameter int STAGE         = 1,
  parameter int CONF_WIDTH    = 24,
  parameter int NUM_THREADS   = 8,
  parameter int PC_WIDTH      = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           en_pc_net,
  input  logic                           conf_valid,
  output logic                           conf_ready,
  input  logic [1:0]                     conf_cmd,
  input  logic [$clog2(NUM_THREADS)-1:0] conf_thread,
  input  logic [PC_WIDTH-1:0]            conf_addr,
  input  logic [CONF_WIDTH-1:0]          conf_data,
  output logic [CONF_WIDTH-1:0]          swicth_conf_out,
  output logic [$clog2(NUM_THREADS)-1:0] swicth_conf_thread,
  output logic [15:0]                    swicth_id
);

  localparam int TW    = $clog2(NUM_THREADS);
  localparam int AW    = TW + PC_WIDTH;
  localparam int DEPTH = NUM_THREADS << PC_WIDTH;
  localparam int NPIPE = STAGE + 3;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Control state
  state_t                 state_q;
  logic [AW-1:0]          init_addr_q;
  logic                   conf_ready_q;

  // Thread sequencing state
  logic [TW-1:0]          tidx_q;
  logic [PC_WIDTH-1:0]    pc_q      [NUM_THREADS];
  logic [PC_WIDTH-1:0]    pc_max_q  [NUM_THREADS];
  logic [PC_WIDTH-1:0]    pc_loop_q [NUM_THREADS];
  logic [NUM_THREADS-1:0] active_q;

  // Configuration memory (not reset; cleared by the INIT sweep)
  logic [CONF_WIDTH-1:0]  mem_q [DEPTH];

  // Read register and output pipe
  logic [CONF_WIDTH-1:0]  rd_data_q;
  logic                   rd_active_q;
  logic [TW-1:0]          rd_tidx_q;
  logic [CONF_WIDTH-1:0]  pipe_data_q   [NPIPE];
  logic                   pipe_active_q [NPIPE];
  logic [TW-1:0]          pipe_tidx_q   [NPIPE];

  // Combinational helpers
  logic                   step;
  logic                   cmd_fire;
  logic [PC_WIDTH-1:0]    pc_cur;
  logic [PC_WIDTH-1:0]    pc_next_d;
  logic [AW-1:0]          rd_addr;
  logic [AW-1:0]          wr_addr;

  assign step     = en_pc_net & (state_q == ST_RUN);
  assign cmd_fire = conf_valid & conf_ready_q;
  assign pc_cur   = pc_q[tidx_q];
  assign rd_addr  = {tidx_q, pc_cur};
  assign wr_addr  = {conf_thread, conf_addr};

  // The loop check takes priority over the increment. This lets pc_max equal
  // the all-ones value and still loop back without wrapping through zero first.
  always_comb begin
    pc_next_d = pc_cur + 1'b1;
    if (pc_cur == pc_max_q[tidx_q]) begin
      pc_next_d = pc_loop_q[tidx_q];
    end
  end

  // INIT/RUN sequencer. conf_ready is registered and rises together with RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_INIT;
      init_addr_q  <= '0;
      conf_ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          init_addr_q <= init_addr_q + 1'b1;
          if (init_addr_q == AW'(DEPTH - 1)) begin
            state_q      <= ST_RUN;
            conf_ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          state_q      <= ST_RUN;
          conf_ready_q <= 1'b1;
        end
        default: begin
          state_q      <= ST_INIT;
          conf_ready_q <= 1'b0;
        end
      endcase
    end
  end

  // Memory write port. While rst is held, state_q is INIT, so the sweep
  // restarts from address 0 when reset is released.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      mem_q[init_addr_q] <= '0;
    end else if (cmd_fire && (conf_cmd == 2'd0)) begin
      mem_q[wr_addr] <= conf_data;
    end
  end

  // Step datapath and command registers. All updates in this block are
  // non-blocking. A same-cycle command therefore cannot affect the step that
  // uses the old pc_max/pc_loop/active values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tidx_q      <= '0;
      active_q    <= '1;
      rd_data_q   <= '0;
      rd_active_q <= 1'b0;
      rd_tidx_q   <= '0;
      for (int i = 0; i < NUM_THREADS; i++) begin
        pc_q[i]      <= '0;
        pc_max_q[i]  <= '0;
        pc_loop_q[i] <= '0;
      end
      for (int i = 0; i < NPIPE; i++) begin
        pipe_data_q[i]   <= '0;
        pipe_active_q[i] <= 1'b0;
        pipe_tidx_q[i]   <= '0;
      end
    end else begin
      if (step) begin
        tidx_q <= tidx_q + 1'b1;
        if (active_q[tidx_q]) begin
          pc_q[tidx_q] <= pc_next_d;
        end
        // A same-cycle write to rd_addr lands after this read, so the old word is returned.
        rd_data_q   <= mem_q[rd_addr];
        rd_active_q <= active_q[tidx_q];
        rd_tidx_q   <= tidx_q;

        pipe_data_q[0]   <= rd_data_q;
        pipe_active_q[0] <= rd_active_q;
        pipe_tidx_q[0]   <= rd_tidx_q;
        for (int i = 1; i < NPIPE; i++) begin
          pipe_data_q[i]   <= pipe_data_q[i-1];
          pipe_active_q[i] <= pipe_active_q[i-1];
          pipe_tidx_q[i]   <= pipe_tidx_q[i-1];
        end
      end

      if (cmd_fire) begin
        case (conf_cmd)
          2'd1:    pc_max_q[conf_thread]  <= conf_data[PC_WIDTH-1:0];
          2'd2:    pc_loop_q[conf_thread] <= conf_data[PC_WIDTH-1:0];
          2'd3:    active_q[conf_thread]  <= conf_data[0];
          default: ;
        endcase
      end
    end
  end

  // The active flag travels with the word. The output is masked to zero for
  // inactive threads, while the thread index still passes through.
  assign swicth_conf_out    = pipe_active_q[NPIPE-1] ? pipe_data_q[NPIPE-1] : '0;
  assign swicth_conf_thread = pipe_tidx_q[NPIPE-1];
  assign conf_ready         = conf_ready_q;
  assign swicth_id          = 16'(SWICTH_NUMBER);

endmodule

// File: doc/swicth_conf_control_gen.md
SWICTH_CONF_CONTROL_GEN -- requirements
Module: swicth_conf_control_gen

Interface
REQ-001 Parameter SWICTH_NUMBER, default 0: switch identifier, exported unchanged on swicth_id.
REQ-002 Parameter STAGE, default 1: extra output pipeline depth; output pipe has STAGE+3 registers.
REQ-003 Parameter CONF_WIDTH, default 24: width of one switch configuration word.
REQ-004 Parameter NUM_THREADS, default 8: thread count, a power of two, at least 2; TW = log2(NUM_THREADS).
REQ-005 Parameter PC_WIDTH, default 1: per-thread program counter width; memory depth is NUM_THREADS*2^PC_WIDTH.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 rst  input  1  reset, asynchronous, active-high.
REQ-008 en_pc_net  input  1  step enable: advances thread counter, selected PC, memory read and output pipe.
REQ-009 conf_valid  input  1  configuration command valid.
REQ-010 conf_ready  output  1  block accepts a command; a transfer occurs when conf_valid & conf_ready at a rising edge.
REQ-011 conf_cmd  input  2  command: 0 write word, 1 set pc_max, 2 set pc_loop, 3 set thread active.
REQ-012 conf_thread  input  TW  target thread.
REQ-013 conf_addr  input  PC_WIDTH  target word address (cmd 0); ignored otherwise.
REQ-014 conf_data  input  CONF_WIDTH  payload: cmd 0 full word; cmd 1/2 bits [PC_WIDTH-1:0]; cmd 3 bit 0.
REQ-015 swicth_conf_out  output  CONF_WIDTH  pipelined configuration word.
REQ-016 swicth_conf_thread  output  TW  thread index aligned with swicth_conf_out.
REQ-017 swicth_id  output  16  constant SWICTH_NUMBER.

Function
REQ-018 States INIT and RUN; rst forces INIT; INIT writes zero to every memory word at one address per cycle, ascending; INIT goes to RUN after the last address is cleared.
REQ-019 conf_ready is 0 in INIT and 1 in RUN; commands offered in INIT are not accepted and have no effect.
REQ-020 In INIT, en_pc_net is ignored: thread counter, PCs and output pipe hold their values.
REQ-021 Thread counter tidx: on en_pc_net in RUN it increments modulo NUM_THREADS.
REQ-022 On a step, the PC of thread tidx, if active, updates to pc_loop[tidx] when pc == pc_max[tidx], else to pc+1; the PCs of other threads hold; the PC of an inactive thread holds.
REQ-023 On a step, memory is read at {tidx, pc[tidx]} using the pre-update PC and latched into the read register; an active flag and tidx are latched alongside.
REQ-024 The read register feeds a STAGE+3 register pipe that advances only on steps; a word read at step k appears on swicth_conf_out after STAGE+4 steps, counting step k.
REQ-025 A word from an inactive thread is driven as zero at the output; swicth_conf_thread still carries its index.
REQ-026 Cmd 0 writes conf_data to {conf_thread, conf_addr}; cmd 1/2 load pc_max/pc_loop of conf_thread; cmd 3 loads active[conf_thread].
REQ-027 Same-cycle write and read of one address: the read returns the old data.
REQ-028 Same-cycle step and cmd 1/2 on thread tidx: the PC update uses the old pc_max/pc_loop.
REQ-029 Same-cycle step and cmd 3 on thread tidx: the step uses the old active bit.
REQ-030 All arithmetic is unsigned; PC increment wraps modulo 2^PC_WIDTH.

Reset
REQ-031 Asserting rst, asynchronously, sets state to INIT, tidx=0, every PC=0, every pc_max=0, every pc_loop=0, every active=1, the read register and all pipe registers to 0, and conf_ready=0.
REQ-032 The memory is not reset by rst; it is cleared by the INIT sweep of NUM_THREADS*2^PC_WIDTH cycles.
REQ-033 rst asserted mid-INIT or mid-RUN restarts the INIT sweep from address 0; a command in flight is dropped.

Verification
REQ-034 Defaults: release rst; conf_ready rises exactly 16 cycles later; outputs are 0 throughout.
REQ-035 Defaults: write T0 addr0=0xAAAAAA and addr1=0x555555, set pc_max[0]=1, then step continuously; thread 0 output alternates 0xAAAAAA, 0x555555 with swicth_conf_thread=0 every 8th step; first appearance is 5 steps after its read.
REQ-036 PC_WIDTH=3, pc_max=5, pc_loop=2: thread 0 PC sequence is 0,1,2,3,4,5,2,3,4,5,2...
REQ-037 Set active[3]=0 mid-run: thread-3 slots output 0 and its PC freezes; re-enable resumes from the frozen PC.
REQ-038 Cmd 0 to the address being read in the same cycle: old word output on this pass, new word on the next pass.
REQ-039 Pulse rst during RUN: all outputs 0 immediately, conf_ready low for the full sweep, and all memory words read back 0 afterwards.
